cl_frame_gen: RTL and testbench

CL_FRAME_GEN -- requirements
Module: cl_frame_gen

---
 rtl/cl_pkg.sv | 19 +
 rtl/cl_pattern.sv | 41 ++++
 rtl/cl_frame_gen.sv | 214 +++++++++++++++++++++
 tb/tb_cl_frame_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_pkg.sv
// Shared types for the Camera Link frame generator: FSM state encoding and test-pattern codes.
package cl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StLine,
        StHblank,
        StVblank
    } cl_state_e;

    typedef enum logic [1:0] {
        PatHRamp   = 2'd0,
        PatVRamp   = 2'd1,
        PatChecker = 2'd2,
        PatConst   = 2'd3
    } cl_pattern_e;

endpackage

// File: rtl/cl_pattern.sv
// Combinational test-pattern source: maps beat index x and line index y to the two tap pixels.
module cl_pattern
    import cl_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned PARAM_WIDTH = 11
) (
    input  logic [PARAM_WIDTH-1:0] x_i,
    input  logic [PARAM_WIDTH-1:0] y_i,
    input  cl_pattern_e            mode_i,
    input  logic [PIXEL_WIDTH-1:0] const_i,
    output logic [PIXEL_WIDTH-1:0] data_l_o,
    output logic [PIXEL_WIDTH-1:0] data_r_o
);

    always_comb begin
        data_l_o = '0;
        data_r_o = '0;
        unique case (mode_i)
            PatHRamp: begin
                // Two pixels per beat: even tap 2x, odd tap 2x+1, wrapping at the pixel width.
                data_l_o = PIXEL_WIDTH'({x_i, 1'b0});
                data_r_o = PIXEL_WIDTH'({x_i, 1'b1});
            end
            PatVRamp: begin
                data_l_o = PIXEL_WIDTH'(y_i);
                data_r_o = PIXEL_WIDTH'(y_i);
            end
            PatChecker: begin
                data_l_o = {PIXEL_WIDTH{x_i[2] ^ y_i[3]}};
                data_r_o = {PIXEL_WIDTH{x_i[2] ^ y_i[3]}};
            end
            PatConst: begin
                data_l_o = const_i;
                data_r_o = const_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cl_frame_gen.sv
// Camera Link frame generator: produces FVAL/LVAL/DVAL timing and two-tap test-pattern data,
// usable as a stand-in camera for loopback of the capture path.
module cl_frame_gen
    import cl_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned PARAM_WIDTH = 11
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   iENABLE,
    input  logic [PARAM_WIDTH-1:0] iHACT,
    input  logic [PARAM_WIDTH-1:0] iHBLANK,
    input  logic [PARAM_WIDTH-1:0] iVACT,
    input  logic [PARAM_WIDTH-1:0] iFV_LEAD,
    input  logic [PARAM_WIDTH-1:0] iVBLANK,
    input  logic [1:0]             iPATTERN,
    input  logic [PIXEL_WIDTH-1:0] iCONST,
    input  logic [3:0]             iDVAL_GAP,
    output logic                   oFVAL,
    output logic                   oLVAL,
    output logic                   oDVAL,
    output logic [PIXEL_WIDTH-1:0] oDATA_L,
    output logic [PIXEL_WIDTH-1:0] oDATA_R,
    output logic                   oFRAME_DONE,
    output logic                   oBUSY
);

    localparam logic [PARAM_WIDTH-1:0] One = PARAM_WIDTH'(1);

    cl_state_e              state_q, state_d;
    logic [PARAM_WIDTH-1:0] cnt_q, cnt_d, x_q, x_d, y_q, y_d;
    logic [PARAM_WIDTH-1:0] hact_q, hact_d, hblank_q, hblank_d;
    logic [PARAM_WIDTH-1:0] vact_q, vact_d, vblank_q, vblank_d;
    logic [3:0]             gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic                   stall_q, stall_d;
    cl_pattern_e            mode_q, mode_d;
    logic [PIXEL_WIDTH-1:0] const_q, const_d;
    logic                   start;

    logic                   fval_q, fval_d, lval_q, lval_d, dval_q, dval_d;
    logic                   done_q, done_d, busy_q, busy_d;
    logic [PIXEL_WIDTH-1:0] data_l_q, data_l_d, data_r_q, data_r_d, pat_l, pat_r;

    // Next-state: sequencing, counters and parameter capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        gap_cnt_d = gap_cnt_q;
        stall_d   = stall_q;
        hact_d    = hact_q;
        hblank_d  = hblank_q;
        vact_d    = vact_q;
        vblank_d  = vblank_q;
        gap_d     = gap_q;
        mode_d    = mode_q;
        const_d   = const_q;
        start     = 1'b0;

        unique case (state_q)
            StIdle: start = iENABLE;
            StLead: begin
                if (cnt_q == '0) begin
                    state_d = StLine;
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            StLine: begin
                if (stall_q) begin
                    stall_d = 1'b0;
                end else if (x_q == hact_q - One) begin
                    gap_cnt_d = '0;
                    x_d       = '0;
                    if (y_q == vact_q - One) begin
                        state_d = StVblank;
                        cnt_d   = vblank_q - One;
                    end else begin
                        y_d = y_q + One;
                        if (hblank_q != '0) begin
                            state_d = StHblank;
                            cnt_d   = hblank_q - One;
                        end
                    end
                end else begin
                    x_d = x_q + One;
                    if (gap_q != '0 && gap_cnt_q + 4'd1 == gap_q) begin
                        stall_d   = 1'b1;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
            end
            StHblank: begin
                if (cnt_q == '0) begin
                    state_d = StLine;
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            StVblank: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - One;
                end else if (iENABLE) begin
                    start = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            hact_d    = (iHACT == '0) ? One : iHACT;
            vact_d    = (iVACT == '0) ? One : iVACT;
            vblank_d  = (iVBLANK == '0) ? One : iVBLANK;
            hblank_d  = iHBLANK;
            gap_d     = iDVAL_GAP;
            mode_d    = cl_pattern_e'(iPATTERN);
            const_d   = iCONST;
            x_d       = '0;
            y_d       = '0;
            gap_cnt_d = '0;
            stall_d   = 1'b0;
            if (iFV_LEAD == '0) begin
                state_d = StLine;
            end else begin
                state_d = StLead;
                cnt_d   = iFV_LEAD - One;
            end
        end
    end

    cl_pattern #(
        .PIXEL_WIDTH(PIXEL_WIDTH),
        .PARAM_WIDTH(PARAM_WIDTH)
    ) u_pattern (
        .x_i     (x_d),
        .y_i     (y_d),
        .mode_i  (mode_d),
        .const_i (const_d),
        .data_l_o(pat_l),
        .data_r_o(pat_r)
    );

    // Outputs are decoded from the next state so qualifiers and data leave the same flops edge.
    always_comb begin
        fval_d   = (state_d == StLead) || (state_d == StLine) || (state_d == StHblank);
        lval_d   = (state_d == StLine);
        dval_d   = lval_d && !stall_d;
        done_d   = (state_d == StVblank) && (state_q != StVblank);
        busy_d   = (state_d != StIdle);
        data_l_d = dval_d ? pat_l : (lval_d ? data_l_q : '0);
        data_r_d = dval_d ? pat_r : (lval_d ? data_r_q : '0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            gap_cnt_q <= '0;
            stall_q   <= 1'b0;
            hact_q    <= '0;
            hblank_q  <= '0;
            vact_q    <= '0;
            vblank_q  <= '0;
            gap_q     <= '0;
            mode_q    <= PatHRamp;
            const_q   <= '0;
            fval_q    <= 1'b0;
            lval_q    <= 1'b0;
            dval_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            data_l_q  <= '0;
            data_r_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            gap_cnt_q <= gap_cnt_d;
            stall_q   <= stall_d;
            hact_q    <= hact_d;
            hblank_q  <= hblank_d;
            vact_q    <= vact_d;
            vblank_q  <= vblank_d;
            gap_q     <= gap_d;
            mode_q    <= mode_d;
            const_q   <= const_d;
            fval_q    <= fval_d;
            lval_q    <= lval_d;
            dval_q    <= dval_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            data_l_q  <= data_l_d;
            data_r_q  <= data_r_d;
        end
    end

    assign oFVAL       = fval_q;
    assign oLVAL       = lval_q;
    assign oDVAL       = dval_q;
    assign oDATA_L     = data_l_q;
    assign oDATA_R     = data_r_q;
    assign oFRAME_DONE = done_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_cl_frame_gen.sv
// Bench for cl_frame_gen: count-based vector table, frame-level reference model and
// hand-written reset / wrap sequences.
module tb_cl_frame_gen;

    localparam int PW = 8;
    localparam int AW = 11;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          iENABLE = 1'b0;
    logic [AW-1:0] iHACT = '0, iHBLANK = '0, iVACT = '0, iFV_LEAD = '0, iVBLANK = '0;
    logic [1:0]    iPATTERN = '0;
    logic [PW-1:0] iCONST = '0;
    logic [3:0]    iDVAL_GAP = '0;
    logic          oFVAL, oLVAL, oDVAL, oFRAME_DONE, oBUSY;
    logic [PW-1:0] oDATA_L, oDATA_R;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    cl_frame_gen #(.PIXEL_WIDTH(PW), .PARAM_WIDTH(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .iENABLE(iENABLE),
        .iHACT(iHACT), .iHBLANK(iHBLANK), .iVACT(iVACT), .iFV_LEAD(iFV_LEAD),
        .iVBLANK(iVBLANK), .iPATTERN(iPATTERN), .iCONST(iCONST), .iDVAL_GAP(iDVAL_GAP),
        .oFVAL(oFVAL), .oLVAL(oLVAL), .oDVAL(oDVAL), .oDATA_L(oDATA_L), .oDATA_R(oDATA_R),
        .oFRAME_DONE(oFRAME_DONE), .oBUSY(oBUSY)
    );

    typedef struct {
        int hact, hblank, vact, lead, vblank, pat, cval, gap;
    } cfg_t;

    typedef struct packed {
        logic          fval, lval, dval;
        logic [PW-1:0] l, r;
        logic          done, busy;
    } obs_t;

    typedef struct {
        cfg_t c;
        int   fval_n, lval_n, dval_n, done_n;
    } vec_t;

    obs_t exp_q[$];

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{fval: oFVAL, lval: oLVAL, dval: oDVAL, l: oDATA_L, r: oDATA_R,
              done: oFRAME_DONE, busy: oBUSY};
        return o;
    endfunction

    function automatic obs_t mk(input logic f, input logic lv, input logic dv,
                                input logic [PW-1:0] l, input logic [PW-1:0] r,
                                input logic dn);
        obs_t o;
        o = '{fval: f, lval: lv, dval: dv, l: l, r: r, done: dn, busy: 1'b1};
        return o;
    endfunction

    function automatic void pix(input cfg_t c, input int x, input int y,
                                output logic [PW-1:0] l, output logic [PW-1:0] r);
        int vl, vr;
        case (c.pat)
            0: begin vl = (2 * x) % (1 << PW); vr = (2 * x + 1) % (1 << PW); end
            1: begin vl = y % (1 << PW); vr = vl; end
            2: begin vl = ((((x / 4) % 2) ^ ((y / 8) % 2)) != 0) ? (1 << PW) - 1 : 0; vr = vl; end
            default: begin vl = c.cval; vr = c.cval; end
        endcase
        l = vl[PW-1:0];
        r = vr[PW-1:0];
    endfunction

    // Whole-frame expected trace, one entry per clock cycle.
    function automatic void build_frame(input cfg_t c);
        int ha, va, vb;
        logic [PW-1:0] l, r;
        ha = (c.hact == 0) ? 1 : c.hact;
        va = (c.vact == 0) ? 1 : c.vact;
        vb = (c.vblank == 0) ? 1 : c.vblank;
        for (int i = 0; i < c.lead; i++) exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        for (int y = 0; y < va; y++) begin
            for (int x = 0; x < ha; x++) begin
                pix(c, x, y, l, r);
                exp_q.push_back(mk(1, 1, 1, l, r, 0));
                if (c.gap != 0 && (x + 1) % c.gap == 0 && x != ha - 1)
                    exp_q.push_back(mk(1, 1, 0, l, r, 0));
            end
            if (y != va - 1)
                for (int i = 0; i < c.hblank; i++) exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < vb; i++) exp_q.push_back(mk(0, 0, 0, 0, 0, i == 0));
    endfunction

    task automatic apply(input cfg_t c);
        iHACT     = AW'(c.hact);
        iHBLANK   = AW'(c.hblank);
        iVACT     = AW'(c.vact);
        iFV_LEAD  = AW'(c.lead);
        iVBLANK   = AW'(c.vblank);
        iPATTERN  = 2'(c.pat);
        iCONST    = PW'(c.cval);
        iDVAL_GAP = 4'(c.gap);
    endtask

    // Starts from IDLE; enable is dropped somewhere inside the last frame.
    task automatic run_model(input string name, input cfg_t c, input int nframes,
                             input bit scramble);
        int len, flen, drop_at;
        obs_t idle;
        idle = '0;
        exp_q.delete();
        for (int f = 0; f < nframes; f++) build_frame(c);
        len     = exp_q.size();
        flen    = len / nframes;
        drop_at = $urandom_range(len - 1, len - flen);
        exp_q.push_back(idle);
        apply(c);
        iENABLE = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == drop_at) iENABLE = 1'b0;
            if (scramble && i == 0) begin
                iHACT     = AW'($urandom_range(0, 30));
                iVACT     = AW'($urandom_range(0, 30));
                iHBLANK   = AW'($urandom_range(0, 30));
                iVBLANK   = AW'($urandom_range(0, 30));
                iFV_LEAD  = AW'($urandom_range(0, 30));
                iPATTERN  = 2'($urandom_range(0, 3));
                iCONST    = PW'($urandom);
                iDVAL_GAP = 4'($urandom_range(0, 15));
            end
            check($sformatf("%s cyc%0d", name, i), 64'(sample()), 64'(exp_q[i]));
            @(posedge CLK); #1;
        end
        iENABLE = 1'b0;
    endtask

    task automatic run_counts(input string name, input vec_t v);
        int fv, lv, dv, dn;
        bit ended;
        fv = 0; lv = 0; dv = 0; dn = 0; ended = 0;
        apply(v.c);
        iENABLE = 1'b1;
        @(posedge CLK); #1;
        iENABLE = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (!oBUSY) begin
                ended = 1;
                break;
            end
            fv += int'(oFVAL);
            lv += int'(oLVAL);
            dv += int'(oDVAL);
            dn += int'(oFRAME_DONE);
            @(posedge CLK); #1;
        end
        check({name, " ended"}, 64'(ended), 64'(1));
        check({name, " fval_cycles"}, 64'(fv), 64'(v.fval_n));
        check({name, " lval_cycles"}, 64'(lv), 64'(v.lval_n));
        check({name, " dval_beats"}, 64'(dv), 64'(v.dval_n));
        check({name, " frame_done"}, 64'(dn), 64'(v.done_n));
    endtask

    vec_t vecs[5];
    cfg_t c;

    initial begin
        // Counts derived by hand from the frame timing rules.
        vecs[0] = '{'{4, 2, 3, 1, 3, 0, 0, 0}, 17, 12, 12, 1};
        vecs[1] = '{'{4, 2, 3, 1, 3, 0, 0, 2}, 20, 15, 12, 1};
        vecs[2] = '{'{0, 0, 0, 0, 3, 1, 0, 0}, 1, 1, 1, 1};
        vecs[3] = '{'{3, 0, 2, 0, 1, 2, 0, 1}, 10, 10, 6, 1};
        vecs[4] = '{'{5, 1, 2, 3, 0, 3, 8'h5a, 4}, 16, 12, 10, 1};

        #3 RST_N = 1'b0;
        #1 check("reset_async", 64'(sample()), 64'(0));
        repeat (2) @(posedge CLK);
        #1 check("reset_held", 64'(sample()), 64'(0));
        @(negedge CLK) RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1 check("idle_no_enable", 64'(sample()), 64'(0));

        for (int i = 0; i < 5; i++) run_counts($sformatf("vec%0d", i), vecs[i]);

        c = '{4, 2, 3, 1, 3, 0, 0, 0};
        run_model("hramp_432", c, 1, 0);
        c = '{4, 2, 3, 1, 3, 0, 0, 2};
        run_model("gap2_stall", c, 1, 0);
        c = '{0, 0, 0, 0, 0, 3, 8'hc3, 0};
        run_model("degenerate", c, 2, 0);

        // Beat 128 of a 200-beat ramp line wraps to 0/1.
        c = '{200, 0, 1, 0, 1, 0, 0, 0};
        apply(c);
        iENABLE = 1'b1;
        @(posedge CLK); #1;
        iENABLE = 1'b0;
        begin
            int beat;
            beat = 0;
            for (int k = 0; k < 400 && oBUSY; k++) begin
                if (oDVAL) begin
                    if (beat == 127) check("wrap_b127", {oDATA_L, oDATA_R}, 64'h feff);
                    if (beat == 128) check("wrap_b128", {oDATA_L, oDATA_R}, 64'h 0001);
                    beat++;
                end
                @(posedge CLK); #1;
            end
            check("wrap_beats", 64'(beat), 64'(200));
            check("wrap_idle", 64'(sample()), 64'(0));
        end

        // Asynchronous reset in the middle of a line, then a clean restart.
        c = '{8, 1, 3, 1, 2, 0, 0, 0};
        apply(c);
        iENABLE = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 50 && seen < 3; k++) begin
                @(posedge CLK); #1;
                if (oLVAL) seen++;
            end
            check("pre_reset_in_line", 64'(oLVAL), 64'(1));
        end
        #2 RST_N = 1'b0;
        #1 check("reset_mid_line", 64'(sample()), 64'(0));
        iENABLE = 1'b0;
        @(negedge CLK) RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1 check("post_reset_idle", 64'(sample()), 64'(0));
        run_model("restart", c, 1, 0);

        for (int t = 0; t < 14; t++) begin
            int nf;
            c.hact   = $urandom_range(0, 12);
            c.hblank = $urandom_range(0, 3);
            c.vact   = $urandom_range(0, 10);
            c.lead   = $urandom_range(0, 3);
            c.vblank = $urandom_range(0, 3);
            c.pat    = $urandom_range(0, 3);
            c.cval   = $urandom_range(0, 255);
            c.gap    = $urandom_range(0, 5);
            nf       = $urandom_range(1, 2);
            run_model($sformatf("rand%0d", t), c, nf, nf == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
